// File: rtl/vector_reverse_pkg.sv
// vector_reverse_pkg: shared FSM state type and mode encodings for vector_reverse_seq.
package vector_reverse_pkg;
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
    localparam logic MODE_PASS = 1'b0;
    localparam logic MODE_REV  = 1'b1;
endpackage

// File: rtl/vr_elem_shifter.sv
// vr_elem_shifter: src/dst element shift pair that moves one GRP-bit element per enabled cycle.
// Ports: clk, rst (sync, active-high), load (capture data, clear dst), data (word in),
//        shift (advance one element), dst_next (dst value after the next shift).
module vr_elem_shifter #(
    parameter int WIDTH = 5,
    parameter int GRP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             shift,
    output logic [WIDTH-1:0] dst_next
);
    logic [WIDTH-1:0] src, dst;
    // The lowest element of src enters dst at the bottom, so the first element
    // shifted ends up at the top after NELEM shifts.
    assign dst_next = (dst << GRP) | WIDTH'(src[GRP-1:0]);
    always_ff @(posedge clk) begin
        if (rst) begin
            src <= '0;
            dst <= '0;
        end else if (load) begin
            src <= data;
            dst <= '0;
        end else if (shift) begin
            src <= src >> GRP;
            dst <= dst_next;
        end
    end
endmodule

// File: rtl/vector_reverse_seq.sv
// vector_reverse_seq: sequential GRP-element reverser with pass/reverse mode and valid/ready output.
// Ports: clk, rst (sync, active-high), load/in/mode (input word, accepted when in_ready),
//        in_ready, out/out_valid/out_ready (held result handshake), busy (shifting).
module vector_reverse_seq
    import vector_reverse_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int GRP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] in,
    input  logic             mode,
    output logic             in_ready,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);
    localparam int NELEM = WIDTH / GRP;
    localparam int CW    = $clog2(NELEM + 1);

    if (WIDTH % GRP != 0 || WIDTH < 2 * GRP) begin : g_bad_params
        $error("vector_reverse_seq: WIDTH must be a multiple of GRP and at least 2*GRP");
    end

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dst_next;

    vr_elem_shifter #(.WIDTH(WIDTH), .GRP(GRP)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (state == IDLE && load),
        .data     (in),
        .shift    (state == SHIFT),
        .dst_next (dst_next)
    );

    assign in_ready  = state == IDLE;
    assign busy      = state == SHIFT;
    assign out_valid = state == HOLD;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            out   <= '0;
        end else begin
            case (state)
                IDLE: if (load) begin
                    cnt   <= '0;
                    state <= mode == MODE_REV ? SHIFT : HOLD;
                    if (mode == MODE_PASS) out <= in;
                end
                SHIFT: begin
                    cnt <= cnt + 1'b1;
                    // Last shift: take the combinational next-dst so the result
                    // is ready in HOLD without an extra cycle.
                    if (cnt == CW'(NELEM - 1)) begin
                        out   <= dst_next;
                        state <= HOLD;
                    end
                end
                HOLD: if (out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_vector_reverse_seq.sv
// tb_vector_reverse_seq: directed bench with scoreboards for a 5x1 and an 8x2 reverser.
module tb_vector_reverse_seq;
    logic       clk = 0;
    logic       rst = 1;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;

    logic       a_load = 0, a_mode = 0, a_out_ready = 0;
    logic [4:0] a_in = '0;
    logic       a_in_ready, a_out_valid, a_busy;
    logic [4:0] a_out;
    logic       b_load = 0, b_mode = 0, b_out_ready = 0;
    logic [7:0] b_in = '0;
    logic       b_in_ready, b_out_valid, b_busy;
    logic [7:0] b_out;

    logic [4:0] qa[$];
    logic [7:0] qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vector_reverse_seq #(.WIDTH(5), .GRP(1)) dut_a (
        .clk(clk), .rst(rst), .load(a_load), .in(a_in), .mode(a_mode),
        .in_ready(a_in_ready), .out(a_out), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .busy(a_busy)
    );

    vector_reverse_seq #(.WIDTH(8), .GRP(2)) dut_b (
        .clk(clk), .rst(rst), .load(b_load), .in(b_in), .mode(b_mode),
        .in_ready(b_in_ready), .out(b_out), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rev5(input logic [4:0] w);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[4-i] = w[i];
        return r;
    endfunction

    // Results are compared when the handshake is about to complete.
    always @(negedge clk) begin
        if (!rst && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) chk("a_sb_unexpected", {27'd0, a_out}, 32'hDEAD);
            else chk("a_sb", {27'd0, a_out}, {27'd0, qa.pop_front()});
        end
        if (!rst && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) chk("b_sb_unexpected", {24'd0, b_out}, 32'hDEAD);
            else chk("b_sb", {24'd0, b_out}, {24'd0, qb.pop_front()});
        end
    end

    initial begin
        int t_prev;
        logic [4:0] w;
        step(2);
        rst = 0;
        chk("rst_out", {27'd0, a_out}, 0);
        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_b_out", {24'd0, b_out}, 0);

        // 5x1 reverse, latency and busy window
        a_in = 5'b11001; a_mode = 1; a_load = 1;
        qa.push_back(5'b10011);
        step();
        a_load = 0;
        for (int i = 0; i < 5; i++) begin
            chk("a_busy_win", a_busy, 1);
            chk("a_valid_early", a_out_valid, 0);
            step();
        end
        chk("a_valid_at_k5", a_out_valid, 1);
        chk("a_busy_done", a_busy, 0);
        chk("a_out_rev", {27'd0, a_out}, 5'b10011);

        // backpressure with ignored load
        a_in = 5'b00111; a_mode = 0; a_load = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_out_held", {27'd0, a_out}, 5'b10011);
            chk("bp_in_ready", a_in_ready, 0);
            chk("bp_valid", a_out_valid, 1);
        end
        a_load = 0; a_out_ready = 1;
        step();
        a_out_ready = 0;
        chk("bp_in_ready_after", a_in_ready, 1);
        chk("bp_valid_drop", a_out_valid, 0);
        chk("bp_out_kept", {27'd0, a_out}, 5'b10011);

        // 8x2 reverse then pass
        b_in = 8'hB4; b_mode = 1; b_load = 1;
        qb.push_back(8'h1E);
        step();
        b_load = 0;
        for (int i = 0; i < 4; i++) begin
            chk("b_busy_win", b_busy, 1);
            step();
        end
        chk("b_valid_at_k4", b_out_valid, 1);
        chk("b_out_rev", {24'd0, b_out}, 8'h1E);
        b_out_ready = 1;
        step();
        b_out_ready = 0;
        b_in = 8'hB4; b_mode = 0; b_load = 1;
        qb.push_back(8'hB4);
        step();
        b_load = 0;
        chk("b_pass_valid", b_out_valid, 1);
        chk("b_pass_busy", b_busy, 0);
        chk("b_pass_out", {24'd0, b_out}, 8'hB4);
        b_out_ready = 1;
        step();
        b_out_ready = 0;

        // 5x1 pass mode
        a_in = 5'b01011; a_mode = 0; a_load = 1;
        qa.push_back(5'b01011);
        step();
        a_load = 0;
        chk("a_pass_valid", a_out_valid, 1);
        chk("a_pass_out", {27'd0, a_out}, 5'b01011);
        a_out_ready = 1;
        step();

        // back-to-back with out_ready held high
        a_mode = 1; a_load = 1;
        t_prev = 0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 20 && !a_in_ready; i++) step();
            chk("b2b_ready", a_in_ready, 1);
            a_in = k[0] ? 5'b00011 : 5'b00001;
            qa.push_back(k[0] ? 5'b11000 : 5'b10000);
            if (k > 0) chk("b2b_period", cyc - t_prev, 7);
            t_prev = cyc;
            step();
        end
        a_load = 0;
        for (int i = 0; i < 40 && qa.size() != 0; i++) step();
        chk("b2b_drained", qa.size(), 0);
        step(2);
        a_out_ready = 0;

        // random reverse words
        a_out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            w = 5'($urandom);
            for (int i = 0; i < 20 && !a_in_ready; i++) step();
            a_in = w; a_load = 1;
            qa.push_back(rev5(w));
            step();
            a_load = 0;
        end
        for (int i = 0; i < 40 && qa.size() != 0; i++) step();
        chk("rand_drained", qa.size(), 0);
        step(2);
        a_out_ready = 0;

        // reset after two shifts
        a_in = 5'b10110; a_mode = 1; a_load = 1;
        step();
        a_load = 0;
        step(2);
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_out", {27'd0, a_out}, 0);
        chk("mid_rst_valid", a_out_valid, 0);
        chk("mid_rst_busy", a_busy, 0);
        chk("mid_rst_in_ready", a_in_ready, 1);

        // new word after reset, mode toggled mid-shift
        a_in = 5'b01101; a_mode = 1; a_load = 1;
        qa.push_back(rev5(5'b01101));
        step();
        a_load = 0; a_mode = 0;
        for (int i = 0; i < 20 && !a_out_valid; i++) step();
        chk("toggle_valid", a_out_valid, 1);
        chk("toggle_out", {27'd0, a_out}, 5'b10110);
        a_out_ready = 1;
        step();
        a_out_ready = 0;
        step(2);
        chk("out_kept_idle", {27'd0, a_out}, 5'b10110);
        chk("idle_in_ready", a_in_ready, 1);

        chk("final_qa", qa.size(), 0);
        chk("final_qb", qb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vector_reverse_seq.md
# vector_reverse_seq

- Parametrised sequential successor to the team's single-cycle vector reverser.
- Accepts a `WIDTH`-bit word and reverses the order of its `GRP`-bit elements, moving one element per clock through a shift engine.
- Adds runtime pass/reverse mode, valid/ready output handshake with backpressure, and a held result register.
- Sits between a producer that presents words with `load` and a consumer that takes results with `out_ready`.

## Interface
Parameters:
- `WIDTH`, default 5: data width in bits; must be a multiple of `GRP` and at least 2*`GRP`.
- `GRP`, default 1: element size in bits; 1 gives bit reversal, 8 gives byte reversal.
- Derived `NELEM` = `WIDTH`/`GRP`; `CW` = clog2(`NELEM`+1).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1: single clock; all state updates on the rising edge.
  - `rst`  in  1: synchronous, active-high reset.
- `load`  in  1: input word valid.
- `in`  in  `WIDTH`: input word.
- `mode`  in  1: 0 = pass-through, 1 = element reverse; sampled with `in`.
- `in_ready`  out  1: block can accept a word.
- `out`  out  `WIDTH`: result register.
- `out_valid`  out  1: `out` holds an unconsumed result.
- `out_ready`  in  1: consumer accepts `out`.
- `busy`  out  1: high in SHIFT.

## Operation
FSM states: IDLE, SHIFT, HOLD.
- Reset: state IDLE; `out`=0, `out_valid`=0, `busy`=0, `in_ready`=1; all internal registers (`src`, `dst`, `cnt`) cleared.
- IDLE:
  - `in_ready`=1.
  - On `load`=1, capture `in` into `src`, clear `dst`, set `cnt`=0.
  - `mode`=1: go to SHIFT.
  - `mode`=0: write `out`<=`in` and go to HOLD.
- SHIFT (`busy`=1, `in_ready`=0), every cycle:
  - `dst`<={`dst`[`WIDTH`-`GRP`-1:0], `src`[`GRP`-1:0]}.
  - `src`>>=`GRP`.
  - `cnt`++.
  - On the cycle with `cnt`==`NELEM`-1, write the shifted value directly to `out` and go to HOLD.
  - Result: element i of the input lands at element position `NELEM`-1-i; bit order inside each element is preserved.
- HOLD (`out_valid`=1, `in_ready`=0):
  - `out` is held stable.
  - On `out_ready`=1, go to IDLE; `out_valid` drops the next cycle.
- `load` is ignored whenever `in_ready`=0; no queuing and no error flag.
- `out` keeps its last result after the handshake until the next result is written (not cleared in IDLE).
- `mode` is only sampled in IDLE on acceptance; changes during SHIFT or HOLD have no effect on the word in flight.
- `rst` in any state aborts the operation, discards the partial result, and applies the reset values above on the next edge.

## Timing
- Acceptance edge k = rising edge with IDLE and `load`=1.
- Reverse mode:
  - `busy`=1 for cycles k+1 .. k+`NELEM`.
  - `out_valid`=1 from edge k+`NELEM`; latency `NELEM` cycles.
- Pass mode: `out_valid`=1 from edge k+1; latency 1 cycle.
- Handshake completes on the edge where `out_valid`=1 and `out_ready`=1. `in_ready`=1 in the following cycle.
- Maximum throughput, with `out_ready` held high:
  - reverse mode: one word per `NELEM`+2 cycles;
  - pass mode: one word per 3 cycles.
- `out_ready` high while `out_valid`=0 has no effect.
- `in_ready`, `busy` and `out_valid` are decoded from the state register only; no combinational path from any input to any output.

## Structure
- `vector_reverse_pkg` holds:
  - the state enum typedef (IDLE/SHIFT/HOLD);
  - mode constants (`MODE_PASS`=0, `MODE_REV`=1).
- Top module `vector_reverse_seq` holds the FSM, `cnt` and the `out` register.
- One sub-module is natural: `vr_elem_shifter` (`WIDTH`, `GRP`).
  - Contains the `src`/`dst` shift pair with load, clear and shift-enable.
  - Exposes the next-`dst` value for the final write.
- Elaboration-time check on `WIDTH` % `GRP` == 0 and `WIDTH` >= 2*`GRP`.

## Test plan
- `WIDTH`=5, `GRP`=1: `rst`=1 for 2 cycles, then `in`=5'b11001, `mode`=1, `load`=1 → `busy` for 5 cycles; `out_valid` at acceptance+5 with `out`=5'b10011.
- `WIDTH`=8, `GRP`=2: `in`=8'hB4, `mode`=1 → `out`=8'h1E after 4 cycles. Same instance with `in`=8'hB4, `mode`=0 → `out`=8'hB4 after 1 cycle.
- Backpressure: hold `out_ready`=0 for 3 cycles while `out_valid`=1, and pulse `load` with `in`=5'b00111 → `out` stays 5'b10011, `load` ignored, `in_ready`=0; raise `out_ready` → IDLE, `in_ready`=1 next cycle.
- Back-to-back: `load`=1 and `out_ready`=1 held continuously with alternating words 5'b00001 and 5'b00011 → outputs 5'b10000 and 5'b11000, one every 7 cycles.
- `rst`=1 mid-SHIFT after 2 shifts → next cycle IDLE with `out`=0, `out_valid`=0, `busy`=0; a new word then completes normally.
- Toggle `mode` from 1 to 0 during SHIFT → result is still the reversed word.
